// File: rtl/pulse_train_gen.sv
// Programmable glitch pulse burst generator: on an armed trigger rise, emits COUNT pulses of
// WIDTH cycles separated by GAP cycles. Configured via the cmd_handler byte-wide register bus.
module pulse_train_gen #(
    parameter logic [7:0] CMD_WIDTH = 8'h30,
    parameter logic [7:0] CMD_GAP   = 8'h31,
    parameter logic [7:0] CMD_COUNT = 8'h32,
    parameter logic [7:0] CMD_CTRL  = 8'h33
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic        trigger_in,
    input  logic [7:0]  reg_cmd,
    input  logic [15:0] reg_bytecount,
    input  logic [7:0]  reg_data_in,
    output logic [7:0]  reg_data_out,
    input  logic        reg_read,
    input  logic        reg_write,
    output logic        pulse_out,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [31:0] width_q, width_d;
    logic [31:0] gap_q, gap_d;
    logic [15:0] count_q, count_d;
    logic        oneshot_q, oneshot_d;
    logic [1:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] remaining_q, remaining_d;
    logic [31:0] sh_width_q, sh_width_d;
    logic [31:0] sh_gap_q, sh_gap_d;
    logic        trig_q, trig_d;
    logic        pulse_q, pulse_d;
    logic [7:0]  rdata_q, rdata_d;

    logic        rise;
    logic        armed;
    logic        ctrl_wr;
    logic [31:0] w_eff, g_eff;
    logic [15:0] c_eff;

    assign rise    = trigger_in & ~trig_q;
    assign armed   = (state_q != S_IDLE);
    assign busy    = (state_q == S_PULSE) || (state_q == S_GAP);
    assign ctrl_wr = reg_write && (reg_cmd == CMD_CTRL) && (reg_bytecount == 16'd0);
    assign w_eff   = (width_q == 32'd0) ? 32'd1 : width_q;
    assign g_eff   = (gap_q == 32'd0) ? 32'd1 : gap_q;
    assign c_eff   = (count_q == 16'd0) ? 16'd1 : count_q;

    // Register file writes; out-of-range byte indices fall through untouched.
    always_comb begin
        width_d   = width_q;
        gap_d     = gap_q;
        count_d   = count_q;
        oneshot_d = oneshot_q;
        if (reg_write) begin
            for (int i = 0; i < 4; i++) begin
                if (reg_bytecount == 16'(i)) begin
                    if (reg_cmd == CMD_WIDTH) width_d[i*8 +: 8] = reg_data_in;
                    if (reg_cmd == CMD_GAP)   gap_d[i*8 +: 8]   = reg_data_in;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (reg_bytecount == 16'(i) && reg_cmd == CMD_COUNT) count_d[i*8 +: 8] = reg_data_in;
            end
        end
        if (ctrl_wr) oneshot_d = reg_data_in[1];
    end

    always_comb begin
        rdata_d = 8'h00;
        if (reg_read) begin
            for (int i = 0; i < 4; i++) begin
                if (reg_bytecount == 16'(i)) begin
                    if (reg_cmd == CMD_WIDTH) rdata_d = width_q[i*8 +: 8];
                    if (reg_cmd == CMD_GAP)   rdata_d = gap_q[i*8 +: 8];
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (reg_bytecount == 16'(i) && reg_cmd == CMD_COUNT) rdata_d = count_q[i*8 +: 8];
            end
            if (reg_cmd == CMD_CTRL && reg_bytecount == 16'd0) rdata_d = {5'b0, busy, oneshot_q, armed};
        end
    end

    // Burst sequencer: cnt_q counts down the cycles left in the current PULSE or GAP phase.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        remaining_d = remaining_q;
        sh_width_d  = sh_width_q;
        sh_gap_d    = sh_gap_q;
        trig_d      = trigger_in;
        case (state_q)
            S_ARMED: begin
                if (rise) begin
                    sh_width_d  = w_eff;
                    sh_gap_d    = g_eff;
                    remaining_d = c_eff;
                    cnt_d       = w_eff - 32'd1;
                    state_d     = S_PULSE;
                end
            end
            S_PULSE: begin
                if (cnt_q == 32'd0) begin
                    if (remaining_q > 16'd1) begin
                        cnt_d   = sh_gap_q - 32'd1;
                        state_d = S_GAP;
                    end else begin
                        state_d = oneshot_q ? S_IDLE : S_ARMED;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 32'd0) begin
                    remaining_d = remaining_q - 16'd1;
                    cnt_d       = sh_width_q - 32'd1;
                    state_d     = S_PULSE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: ;
        endcase
        // A CTRL write overrides the sequencer: arming only leaves IDLE, clearing bit0 aborts.
        if (ctrl_wr) begin
            if (reg_data_in[0]) begin
                if (state_q == S_IDLE) state_d = S_ARMED;
            end else begin
                state_d = S_IDLE;
            end
        end
        pulse_d = (state_d == S_PULSE);
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            width_q     <= 32'd1;
            gap_q       <= 32'd1;
            count_q     <= 16'd1;
            oneshot_q   <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= 32'd0;
            remaining_q <= 16'd0;
            sh_width_q  <= 32'd1;
            sh_gap_q    <= 32'd1;
            trig_q      <= 1'b1;
            pulse_q     <= 1'b0;
            rdata_q     <= 8'h00;
        end else begin
            width_q     <= width_d;
            gap_q       <= gap_d;
            count_q     <= count_d;
            oneshot_q   <= oneshot_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            remaining_q <= remaining_d;
            sh_width_q  <= sh_width_d;
            sh_gap_q    <= sh_gap_d;
            trig_q      <= trig_d;
            pulse_q     <= pulse_d;
            rdata_q     <= rdata_d;
        end
    end

    assign pulse_out    = pulse_q;
    assign reg_data_out = rdata_q;
    assign state_dbg    = state_q;

endmodule
